// File: rtl/ntt_pkg.sv
// Shared widths and write-back FSM encoding for the NTT core datapath.
package ntt_pkg;
  localparam int MAX_BEATS  = 512;
  localparam int COEFF_W    = 30;
  localparam int WORD_W     = 2 * COEFF_W;
  localparam int ADDR_W     = 9;
  localparam int CNT_W      = $clog2(MAX_BEATS + 1);
  localparam int BF_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;
endpackage

// File: rtl/ntt_addr_delay.sv
// Reset-clearable shift register carrying {valid, addr, parity} alongside a pipelined datapath.
// The MSB of each word is treated as its valid flag so callers can tell when the line is empty.
module ntt_addr_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         any_valid
);
  logic [W-1:0]     stage_reg [DEPTH];
  logic [DEPTH-1:0] valid_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi][W-1];
    end
  endgenerate

  assign data_out  = stage_reg[DEPTH-1];
  assign any_valid = |valid_vec;
endmodule

// File: rtl/ntt_writeback_unit.sv
// Re-aligns butterfly results with their read address and packs them into upper/lower RAM
// writes, either in place (PASS) or interleaving even/odd beats (PAIR).
module ntt_writeback_unit
  import ntt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pair_mode,
  input  logic [CNT_W-1:0]   beat_count,
  input  logic               issue_valid,
  input  logic [ADDR_W-1:0]  issue_addr,
  input  logic [COEFF_W-1:0] r1,
  input  logic [COEFF_W-1:0] r2,
  input  logic [COEFF_W-1:0] r3,
  input  logic [COEFF_W-1:0] r4,
  output logic               upper_write_enable,
  output logic [ADDR_W-1:0]  upper_write_address,
  output logic [WORD_W-1:0]  upper_write_data,
  output logic               lower_write_enable,
  output logic [ADDR_W-1:0]  lower_write_address,
  output logic [WORD_W-1:0]  lower_write_data,
  output logic               busy,
  output logic               done,
  output logic               pair_error
);
  localparam int DL_W = ADDR_W + 2;

  wb_state_t          state_reg, state_next;
  logic               mode_reg;
  logic [CNT_W-1:0]   count_reg, issued_reg;
  logic               start_ok, accept, flush;
  logic [DL_W-1:0]    dl_in, dl_out;
  logic               dl_busy, res_valid, res_odd;
  logic [ADDR_W-1:0]  res_addr;

  logic               hold_valid_reg;
  logic [ADDR_W-1:0]  hold_addr_reg;
  logic [COEFF_W-1:0] hold_r1_reg, hold_r2_reg, hold_r3_reg, hold_r4_reg;

  logic               q_valid_reg;
  logic [ADDR_W-1:0]  q_addr_reg;
  logic [WORD_W-1:0]  q_upper_reg, q_lower_reg;

  logic               we_reg, pair_error_reg;
  logic [ADDR_W-1:0]  wr_addr_reg;
  logic [WORD_W-1:0]  up_data_reg, lo_data_reg;

  assign start_ok = start && (state_reg == IDLE);
  assign accept   = issue_valid && (state_reg == RUN) && (issued_reg < count_reg);
  // Parity comes from the beat index, so any base address pairs correctly.
  assign dl_in    = {accept, {ADDR_W{accept}} & issue_addr, issued_reg[0]};

  ntt_addr_delay #(.DEPTH(BF_LATENCY), .W(DL_W)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .data_in   (dl_in),
    .data_out  (dl_out),
    .any_valid (dl_busy)
  );

  assign res_valid = dl_out[DL_W-1];
  assign res_addr  = dl_out[DL_W-2:1];
  assign res_odd   = dl_out[0];
  // An even beat still held once everything else has drained has no partner coming.
  assign flush     = (state_reg == DRAIN) && !dl_busy && !q_valid_reg && hold_valid_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issued_reg == count_reg) state_next = DRAIN;
      DRAIN:   if (!dl_busy && !q_valid_reg && !hold_valid_reg) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mode_reg       <= 1'b0;
      count_reg      <= '0;
      issued_reg     <= '0;
      pair_error_reg <= 1'b0;
      hold_valid_reg <= 1'b0;
      hold_addr_reg  <= '0;
      hold_r1_reg    <= '0;
      hold_r2_reg    <= '0;
      hold_r3_reg    <= '0;
      hold_r4_reg    <= '0;
      q_valid_reg    <= 1'b0;
      q_addr_reg     <= '0;
      q_upper_reg    <= '0;
      q_lower_reg    <= '0;
      we_reg         <= 1'b0;
      wr_addr_reg    <= '0;
      up_data_reg    <= '0;
      lo_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= 1'b0;

      if (start_ok) begin
        mode_reg       <= pair_mode;
        count_reg      <= beat_count;
        issued_reg     <= '0;
        pair_error_reg <= 1'b0;
      end else if (accept) begin
        issued_reg <= issued_reg + CNT_W'(1);
      end

      if (res_valid && !mode_reg) begin
        we_reg      <= 1'b1;
        wr_addr_reg <= res_addr;
        up_data_reg <= {r2, r1};
        lo_data_reg <= {r4, r3};
      end else if (res_valid && res_odd) begin
        // First half goes out now at the even address; the second half takes the next slot.
        we_reg         <= 1'b1;
        wr_addr_reg    <= hold_addr_reg;
        up_data_reg    <= {r1, hold_r1_reg};
        lo_data_reg    <= {r3, hold_r3_reg};
        q_valid_reg    <= 1'b1;
        q_addr_reg     <= res_addr;
        q_upper_reg    <= {r2, hold_r2_reg};
        q_lower_reg    <= {r4, hold_r4_reg};
        hold_valid_reg <= 1'b0;
      end else if (res_valid) begin
        hold_valid_reg <= 1'b1;
        hold_addr_reg  <= res_addr;
        hold_r1_reg    <= r1;
        hold_r2_reg    <= r2;
        hold_r3_reg    <= r3;
        hold_r4_reg    <= r4;
        if (q_valid_reg) begin
          we_reg      <= 1'b1;
          wr_addr_reg <= q_addr_reg;
          up_data_reg <= q_upper_reg;
          lo_data_reg <= q_lower_reg;
          q_valid_reg <= 1'b0;
        end
      end else if (q_valid_reg) begin
        we_reg      <= 1'b1;
        wr_addr_reg <= q_addr_reg;
        up_data_reg <= q_upper_reg;
        lo_data_reg <= q_lower_reg;
        q_valid_reg <= 1'b0;
      end else if (flush) begin
        we_reg         <= 1'b1;
        wr_addr_reg    <= hold_addr_reg;
        up_data_reg    <= {hold_r2_reg, hold_r1_reg};
        lo_data_reg    <= {hold_r4_reg, hold_r3_reg};
        hold_valid_reg <= 1'b0;
        pair_error_reg <= 1'b1;
      end
    end
  end

  assign upper_write_enable  = we_reg;
  assign upper_write_address = wr_addr_reg;
  assign upper_write_data    = up_data_reg;
  assign lower_write_enable  = we_reg;
  assign lower_write_address = wr_addr_reg;
  assign lower_write_data    = lo_data_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = (state_reg == DONE);
  assign pair_error          = pair_error_reg;
endmodule
